// File: rtl/embed_mem_test_engine.sv
// embed_mem_test_engine
// Command-driven memory test sequencer that owns the s1-style port of the
// 4000x32 single-port on-chip RAM. It fills a word range with a
// self-addressing pattern (pattern + i), verifies a range against that
// pattern, and optionally sums a range.
//
// Optional feature: define MEM_TEST_CHECKSUM_EN to enable the CHECKSUM
// command (op 2). Without it, op 2 is rejected with cmd_err and checksum
// is tied to zero.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only while idle)
//   cmd_op              : 0 FILL, 1 VERIFY, 2 CHECKSUM, 3 illegal
//   cmd_base/cmd_len    : first word address / word count (0..DEPTH)
//   cmd_pattern         : seed, word i expects cmd_pattern + i
//   hold                : freezes the engine and the RAM clock enable
//   busy/done/cmd_err   : status; done pulses at command end
//   err_count           : VERIFY mismatch count (saturates at DEPTH)
//   first_err_addr      : address of the first VERIFY mismatch
//   checksum            : CHECKSUM result
//   mem_*               : RAM port (address, byteenable, chipselect,
//                         write, writedata, clken, readdata)
module embed_mem_test_engine #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [DATA_W-1:0] cmd_pattern,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              cmd_err,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1);
  localparam logic [1:0]        OP_FILL     = 2'd0;
  localparam logic [1:0]        OP_VERIFY   = 2'd1;
  localparam logic [1:0]        OP_CHECKSUM = 2'd2;
  localparam logic [1:0]        OP_ILLEGAL  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q;
  logic [1:0]        op_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt_q;        // index of the access currently on the port
  logic [DATA_W-1:0] pattern_q;
  logic              pipe_vld_q;   // a read issued last cycle returns data now
  logic [ADDR_W:0]   pipe_idx_q;
  logic [ADDR_W-1:0] pipe_addr_q;
  logic              cmd_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              cmd_err_q;
  logic [ADDR_W:0]   err_count_q;
  logic [ADDR_W-1:0] first_err_addr_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic              mem_chipselect_q;
  logic              mem_write_q;
  logic [DATA_W-1:0] mem_writedata_q;

  logic [ADDR_W-1:0] addr_next_d;
  logic              cmd_bad_d;
  logic              last_d;
  logic [DATA_W-1:0] expect_d;
  logic              mismatch_d;
  logic [ADDR_W:0]   err_count_d;
  logic [ADDR_W-1:0] first_err_addr_d;

  // Command decode and next-address/compare helpers.
  always_comb begin
    addr_next_d = (mem_address_q == LAST_ADDR) ? '0 : (mem_address_q + ADDR_ONE);
`ifdef MEM_TEST_CHECKSUM_EN
    cmd_bad_d = (cmd_op == OP_ILLEGAL) || (cmd_len > DEPTH_LEN) ||
                ({1'b0, cmd_base} >= DEPTH_LEN);
`else
    cmd_bad_d = (cmd_op == OP_ILLEGAL) || (cmd_op == OP_CHECKSUM) ||
                (cmd_len > DEPTH_LEN) || ({1'b0, cmd_base} >= DEPTH_LEN);
`endif
    last_d     = (cnt_q == (len_q - LEN_ONE));
    expect_d   = pattern_q + DATA_W'(pipe_idx_q);
    mismatch_d = pipe_vld_q && (op_q == OP_VERIFY) && (mem_readdata != expect_d);
  end

  // VERIFY result update for the word returning this cycle.
  always_comb begin
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    if (mismatch_d) begin
      if (err_count_q == '0) begin
        first_err_addr_d = pipe_addr_q;
      end else begin
        first_err_addr_d = first_err_addr_q;
      end
      if (err_count_q != DEPTH_LEN) begin
        err_count_d = err_count_q + LEN_ONE;
      end else begin
        err_count_d = err_count_q;
      end
    end else begin
      err_count_d      = err_count_q;
      first_err_addr_d = first_err_addr_q;
    end
  end

  // Main sequencer: state, counters, read pipeline and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      op_q             <= 2'd0;
      len_q            <= '0;
      cnt_q            <= '0;
      pattern_q        <= '0;
      pipe_vld_q       <= 1'b0;
      pipe_idx_q       <= '0;
      pipe_addr_q      <= '0;
      cmd_ready_q      <= 1'b1;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      cmd_err_q        <= 1'b0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      mem_address_q    <= '0;
      mem_chipselect_q <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_writedata_q  <= '0;
    end else begin
      case (state_q)
        // hold is deliberately ignored here: it must not block acceptance.
        S_IDLE: begin
          if (cmd_valid) begin
            op_q             <= cmd_op;
            len_q            <= cmd_len;
            pattern_q        <= cmd_pattern;
            cnt_q            <= '0;
            pipe_vld_q       <= 1'b0;
            cmd_ready_q      <= 1'b0;
            busy_q           <= 1'b1;
            cmd_err_q        <= cmd_bad_d;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            if (cmd_bad_d || (cmd_len == '0)) begin
              state_q          <= S_DONE;
              done_q           <= 1'b1;
              mem_chipselect_q <= 1'b0;
              mem_write_q      <= 1'b0;
              mem_address_q    <= '0;
              mem_writedata_q  <= '0;
            end else begin
              state_q          <= (cmd_op == OP_FILL) ? S_FILL : S_READ;
              mem_chipselect_q <= 1'b1;
              mem_write_q      <= (cmd_op == OP_FILL);
              mem_address_q    <= cmd_base;
              mem_writedata_q  <= cmd_pattern;
            end
          end
        end
        S_FILL: begin
          if (!hold) begin
            if (last_d) begin
              state_q          <= S_DONE;
              done_q           <= 1'b1;
              mem_chipselect_q <= 1'b0;
              mem_write_q      <= 1'b0;
              mem_address_q    <= '0;
              mem_writedata_q  <= '0;
            end else begin
              cnt_q           <= cnt_q + LEN_ONE;
              mem_address_q   <= addr_next_d;
              mem_writedata_q <= mem_writedata_q + DATA_ONE;
            end
          end
        end
        S_READ: begin
          if (!hold) begin
            pipe_vld_q       <= 1'b1;
            pipe_idx_q       <= cnt_q;
            pipe_addr_q      <= mem_address_q;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            if (last_d) begin
              state_q          <= S_DRAIN;
              mem_chipselect_q <= 1'b0;
              mem_address_q    <= '0;
            end else begin
              cnt_q         <= cnt_q + LEN_ONE;
              mem_address_q <= addr_next_d;
            end
          end
        end
        // Consume the final read; nothing new is issued.
        S_DRAIN: begin
          if (!hold) begin
            pipe_vld_q       <= 1'b0;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            state_q          <= S_DONE;
            done_q           <= 1'b1;
          end
        end
        S_DONE: begin
          if (!hold) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q          <= S_IDLE;
          done_q           <= 1'b0;
          busy_q           <= 1'b0;
          cmd_ready_q      <= 1'b1;
          mem_chipselect_q <= 1'b0;
          mem_write_q      <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_TEST_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  // Checksum accumulator: cleared on acceptance, sums returning read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else if ((state_q == S_IDLE) && cmd_valid) begin
      csum_q <= '0;
    end else if (!hold && pipe_vld_q && (op_q == OP_CHECKSUM)) begin
      csum_q <= csum_q + mem_readdata;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign cmd_err        = cmd_err_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;
  assign mem_address    = mem_address_q;
  assign mem_chipselect = mem_chipselect_q;
  assign mem_write      = mem_write_q;
  assign mem_writedata  = mem_writedata_q;
  assign mem_byteenable = mem_chipselect_q ? 4'b1111 : 4'b0000;
  assign mem_clken      = ~hold;

endmodule

// File: tb/tb_embed_mem_test_engine.sv
module tb_embed_mem_test_engine;

  localparam int DEPTH = 4000;
`ifdef MEM_TEST_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [11:0] cmd_base;
  logic [12:0] cmd_len;
  logic [31:0] cmd_pattern;
  logic        hold;
  logic        busy;
  logic        done;
  logic        cmd_err;
  logic [12:0] err_count;
  logic [11:0] first_err_addr;
  logic [31:0] checksum;
  logic [11:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic [31:0] mem_readdata;

  embed_mem_test_engine dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_base       (cmd_base),
    .cmd_len        (cmd_len),
    .cmd_pattern    (cmd_pattern),
    .hold           (hold),
    .busy           (busy),
    .done           (done),
    .cmd_err        (cmd_err),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .checksum       (checksum),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  always #5 clk = ~clk;

  // RAM: registered address, data visible the cycle after the read address.
  logic [31:0] ram [0:DEPTH-1];
  logic [31:0] ram_rd_q;
  logic        poke_en;
  logic [11:0] poke_addr;
  logic [31:0] poke_data;

  always @(posedge clk) begin
    if (poke_en) begin
      ram[poke_addr] <= poke_data;
    end else if (mem_clken && mem_chipselect && (mem_address < 12'd4000)) begin
      if (mem_write) ram[mem_address] <= mem_writedata;
      ram_rd_q <= ram[mem_address];
    end
  end
  assign mem_readdata = ram_rd_q;

  // Expected per-cycle view of the DUT.
  typedef struct {
    int          c;
    bit          rdy, busy, done, err, cs, we, clken, strict, res;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [12:0] ecnt;
    logic [11:0] efirst;
    logic [31:0] csum;
  } exp_t;

  exp_t q[$];
  exp_t cur_e;
  int   n_total = 0;
  int   n_pass  = 0;
  int   last_done_c = -1;
  logic last_done_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  // Compare process: one expected entry per cycle while a command runs.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      cur_e = q.pop_front();
      chk($sformatf("cmd_ready c%0d", cur_e.c), {31'd0, cmd_ready}, {31'd0, cur_e.rdy});
      chk($sformatf("busy c%0d", cur_e.c), {31'd0, busy}, {31'd0, cur_e.busy});
      chk($sformatf("done c%0d", cur_e.c), {31'd0, done}, {31'd0, cur_e.done});
      chk($sformatf("chipselect c%0d", cur_e.c), {31'd0, mem_chipselect}, {31'd0, cur_e.cs});
      chk($sformatf("write c%0d", cur_e.c), {31'd0, mem_write}, {31'd0, cur_e.we});
      chk($sformatf("byteenable c%0d", cur_e.c), {28'd0, mem_byteenable},
          cur_e.cs ? 32'h0000_000F : 32'h0000_0000);
      chk($sformatf("clken c%0d", cur_e.c), {31'd0, mem_clken}, {31'd0, cur_e.clken});
      if (cur_e.cs || cur_e.strict)
        chk($sformatf("address c%0d", cur_e.c), {20'd0, mem_address}, {20'd0, cur_e.addr});
      if (cur_e.we || cur_e.strict)
        chk($sformatf("writedata c%0d", cur_e.c), mem_writedata, cur_e.wdata);
      if (cur_e.done || cur_e.strict)
        chk($sformatf("cmd_err c%0d", cur_e.c), {31'd0, cmd_err}, {31'd0, cur_e.err});
      if (cur_e.res) begin
        chk($sformatf("err_count c%0d", cur_e.c), {19'd0, err_count}, {19'd0, cur_e.ecnt});
        chk($sformatf("first_err_addr c%0d", cur_e.c), {20'd0, first_err_addr}, {20'd0, cur_e.efirst});
        chk($sformatf("checksum c%0d", cur_e.c), checksum, cur_e.csum);
      end
      if (done) begin
        last_done_c   <= cur_e.c;
        last_done_err <= cmd_err;
      end
    end
  end

  // Behavioural model: memory image plus per-command result/latency rules.
  logic [31:0] shadow [0:DEPTH-1];
  int          m_op, m_base, m_len, m_ndone;
  logic [31:0] m_pat;
  bit          m_bad;
  logic [12:0] m_ecnt;
  logic [11:0] m_first;
  logic [31:0] m_csum;

  task automatic model_cmd(input int op, input int base, input int len,
                           input logic [31:0] pat, input bit commit);
    int a;
    m_op = op; m_base = base; m_len = len; m_pat = pat;
    m_bad = (op == 3) || ((op == 2) && !CSUM_EN) || (len > DEPTH) || (base >= DEPTH);
    m_ecnt = 13'd0; m_first = 12'd0; m_csum = 32'd0;
    if (m_bad || (len == 0)) m_ndone = 1;
    else if (op == 0) m_ndone = len + 1;
    else m_ndone = len + 2;
    if (!m_bad) begin
      for (int i = 0; i < len; i++) begin
        a = (base + i) % DEPTH;
        if (op == 1) begin
          if (shadow[a] != pat + 32'(i)) begin
            if (m_ecnt == 13'd0) m_first = 12'(a);
            if (m_ecnt < 13'd4000) m_ecnt = m_ecnt + 13'd1;
          end
        end else if (op == 2) begin
          m_csum = m_csum + shadow[a];
        end else if (commit) begin
          shadow[a] = pat + 32'(i);
        end
      end
    end
  endtask

  // Expected outputs after p un-held cycles of progress since acceptance.
  function automatic exp_t nominal(input int c, input int p, input bit hold_c);
    exp_t e;
    e.c = c; e.rdy = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.err = 1'b0;
    e.cs = 1'b0; e.we = 1'b0; e.clken = !hold_c; e.strict = 1'b0; e.res = 1'b0;
    e.addr = 12'd0; e.wdata = 32'd0;
    e.ecnt = m_ecnt; e.efirst = m_first; e.csum = m_csum;
    if ((p == 0) || (p > m_ndone)) begin
      e.rdy = 1'b1;
      e.res = (p > m_ndone);
    end else begin
      e.busy = 1'b1;
      if (p == m_ndone) begin
        e.done = 1'b1; e.err = m_bad; e.res = 1'b1;
      end else if (p <= m_len) begin
        e.cs = 1'b1;
        e.we = (m_op == 0);
        e.addr = 12'((m_base + p - 1) % DEPTH);
        e.wdata = m_pat + 32'(p - 1);
      end
    end
    return e;
  endfunction

  function automatic exp_t rst_entry(input int c);
    exp_t e;
    e.c = c; e.rdy = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.err = 1'b0;
    e.cs = 1'b0; e.we = 1'b0; e.clken = 1'b1; e.strict = 1'b1; e.res = 1'b1;
    e.addr = 12'd0; e.wdata = 32'd0; e.ecnt = 13'd0; e.efirst = 12'd0; e.csum = 32'd0;
    return e;
  endfunction

  // Issue one command at the current cycle (called just after a rising edge).
  task automatic run_cmd(input int op, input int base, input int len,
                         input logic [31:0] pat, input logic [31:0] hold_mask);
    int p, c, last;
    bit hc;
    model_cmd(op, base, len, pat, 1'b1);
    p = 0; c = 0;
    q.push_back(nominal(0, 0, hold_mask[0]));
    while ((p <= m_ndone) && (c < 60)) begin
      c++;
      if ((c == 1) || (c > 32) || !hold_mask[c-1]) p++;
      hc = (c < 32) ? hold_mask[c] : 1'b0;
      q.push_back(nominal(c, p, hc));
    end
    last = c;
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_base = 12'(base);
    cmd_len = 13'(len); cmd_pattern = pat; hold = hold_mask[0];
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      hold = (k < 32) ? hold_mask[k] : 1'b0;
    end
    @(posedge clk); #1;
    hold = 1'b0;
  endtask

  task automatic poke(input int addr, input logic [31:0] data);
    poke_en = 1'b1; poke_addr = 12'(addr); poke_data = data;
    @(posedge clk); #1;
    poke_en = 1'b0;
    shadow[addr] = data;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_base = 12'd0;
    cmd_len = 13'd0; cmd_pattern = 32'd0; hold = 1'b0;
    poke_en = 1'b0; poke_addr = 12'd0; poke_data = 32'd0;
    q.push_back(rst_entry(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // FILL 0..3 then VERIFY
    run_cmd(0, 0, 4, 32'h1000_0000, 32'h0);
    chk("lit fill done cycle", last_done_c, 32'd5);
    run_cmd(1, 0, 4, 32'h1000_0000, 32'h0);
    chk("lit verify done cycle", last_done_c, 32'd6);
    chk("lit verify clean err_count", {19'd0, err_count}, 32'd0);

    // CHECKSUM over the same words
    run_cmd(2, 0, 4, 32'h0, 32'h0);
`ifdef MEM_TEST_CHECKSUM_EN
    chk("lit checksum value", checksum, 32'h4000_0006);
    chk("lit checksum cmd_err", {31'd0, last_done_err}, 32'd0);
`else
    chk("lit checksum value disabled", checksum, 32'h0);
    chk("lit checksum cmd_err disabled", {31'd0, last_done_err}, 32'd1);
`endif

    // Corrupt word 2, VERIFY again
    poke(2, 32'h0);
    run_cmd(1, 0, 4, 32'h1000_0000, 32'h0);
    chk("lit corrupt err_count", {19'd0, err_count}, 32'd1);
    chk("lit corrupt first_err_addr", {20'd0, first_err_addr}, 32'd2);

    // Wrap-around fill and verify at the top of memory
    run_cmd(0, 3998, 4, 32'hA5A5_0000, 32'h0);
    run_cmd(1, 3998, 4, 32'hA5A5_0000, 32'h0);
    chk("lit wrap verify err_count", {19'd0, err_count}, 32'd0);

    // VERIFY len 8, without and with hold on cycles 3..5
    run_cmd(0, 100, 8, 32'h1234_5678, 32'h0);
    poke(105, 32'hDEAD_BEEF);
    run_cmd(1, 100, 8, 32'h1234_5678, 32'h0);
    chk("lit nohold done cycle", last_done_c, 32'd10);
    chk("lit nohold err_count", {19'd0, err_count}, 32'd1);
    run_cmd(1, 100, 8, 32'h1234_5678, 32'h0000_0038);
    chk("lit hold done cycle", last_done_c, 32'd13);
    chk("lit hold err_count", {19'd0, err_count}, 32'd1);
    chk("lit hold first_err_addr", {20'd0, first_err_addr}, 32'd105);

    // len 0 and error commands
    run_cmd(1, 0, 0, 32'h0, 32'h0);
    chk("lit len0 done cycle", last_done_c, 32'd1);
    chk("lit len0 cmd_err", {31'd0, last_done_err}, 32'd0);
    run_cmd(3, 0, 4, 32'h0, 32'h0);
    chk("lit op3 cmd_err", {31'd0, last_done_err}, 32'd1);
    run_cmd(0, 0, 4001, 32'h0, 32'h0);
    chk("lit len>depth cmd_err", {31'd0, last_done_err}, 32'd1);
    run_cmd(1, 4000, 1, 32'h0, 32'h0);
    chk("lit base>=depth cmd_err", {31'd0, last_done_err}, 32'd1);

    // hold in IDLE does not block acceptance
    run_cmd(0, 300, 2, 32'h5555_0000, 32'h0000_0001);
    chk("lit idle-hold done cycle", last_done_c, 32'd3);

    // Reset during FILL at cycle 3
    model_cmd(0, 200, 6, 32'hC0DE_0000, 1'b0);
    for (int c = 0; c < 3; c++) q.push_back(nominal(c, c, 1'b0));
    q.push_back(rst_entry(3));
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_base = 12'd200;
    cmd_len = 13'd6; cmd_pattern = 32'hC0DE_0000;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    shadow[200] = 32'hC0DE_0000;
    shadow[201] = 32'hC0DE_0001;
    run_cmd(1, 200, 2, 32'hC0DE_0000, 32'h0);
    chk("lit post-reset done cycle", last_done_c, 32'd4);
    chk("lit post-reset err_count", {19'd0, err_count}, 32'd0);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
